// File: rtl/i2c_reg_responder_pkg.sv
// Shared camera I2C definitions: responder FSM encodings, default device address, helpers.
package i2c_reg_responder_pkg;

    localparam logic [6:0]  CAM_DEV_ADDR = 7'h3C;
    localparam int unsigned STATE_W      = 4;
    localparam int unsigned BIT_CNT_W    = 3;

    localparam logic [3:0] ST_IDLE    = 4'd0;
    localparam logic [3:0] ST_DEV     = 4'd1;
    localparam logic [3:0] ST_ACK_DEV = 4'd2;
    localparam logic [3:0] ST_AHI     = 4'd3;
    localparam logic [3:0] ST_ACK_AHI = 4'd4;
    localparam logic [3:0] ST_ALO     = 4'd5;
    localparam logic [3:0] ST_ACK_ALO = 4'd6;
    localparam logic [3:0] ST_WDATA   = 4'd7;
    localparam logic [3:0] ST_ACK_W   = 4'd8;
    localparam logic [3:0] ST_RDATA   = 4'd9;
    localparam logic [3:0] ST_MACK    = 4'd10;

    // Address byte on the wire carries the 7-bit address in [7:1], R/W in [0].
    function automatic logic dev_match(input logic [7:0] addr_byte, input logic [6:0] dev_addr);
        return addr_byte[7:1] == dev_addr;
    endfunction

endpackage

// File: rtl/i2c_reg_responder_line_filter.sv
// i2c_line_filter: 2-FF synchronizer followed by a run-length filter that only
// accepts a new level after FILT_LEN consecutive equal synchronized samples.
module i2c_line_filter #(
    parameter int unsigned FILT_LEN = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic i_line,
    output logic o_level
);

    localparam int unsigned CNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

    logic [1:0]       r_sync;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;

    // r_cnt counts consecutive samples that disagree with the accepted level.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync  <= 2'b11;
            r_cnt   <= '0;
            r_level <= 1'b1;
        end else begin
            r_sync <= {r_sync[0], i_line};
            if (r_sync[1] == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_W'(FILT_LEN - 1)) begin
                r_level <= r_sync[1];
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_level = r_level;

endmodule

// File: rtl/i2c_reg_responder.sv
// I2C slave bridging bus transfers to a 16-bit-addressed register port with
// auto-increment; decodes only filtered SCL/SDA levels.
module i2c_reg_responder
    import i2c_reg_responder_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR = CAM_DEV_ADDR,
    parameter int unsigned FILT_LEN = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scl_i,
    input  logic        sda_i,
    output logic        sda_oe,
    output logic [15:0] reg_addr,
    output logic        reg_wr_en,
    output logic [7:0]  reg_wr_data,
    input  logic [7:0]  reg_rd_data,
    output logic        busy
);

    logic w_scl;
    logic w_sda;
    logic r_scl_d;
    logic r_sda_d;

    i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
        .clk     (clk),
        .rst     (rst),
        .i_line  (scl_i),
        .o_level (w_scl)
    );

    i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
        .clk     (clk),
        .rst     (rst),
        .i_line  (sda_i),
        .o_level (w_sda)
    );

    logic w_scl_rise;
    logic w_scl_fall;
    logic w_start;
    logic w_stop;

    assign w_scl_rise = w_scl & ~r_scl_d;
    assign w_scl_fall = ~w_scl & r_scl_d;
    assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
    assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;

    logic [STATE_W-1:0]   r_state;
    logic [BIT_CNT_W-1:0] r_cnt;
    logic [7:0]           r_shift;
    logic [7:0]           r_addr_hi;
    logic                 r_rw;
    logic                 r_sda_oe;
    logic [15:0]          r_addr;
    logic                 r_wr_en;
    logic [7:0]           r_wr_data;
    logic                 r_busy;

    logic [STATE_W-1:0]   w_state_nxt;
    logic [BIT_CNT_W-1:0] w_cnt_nxt;
    logic [7:0]           w_shift_nxt;
    logic [7:0]           w_addr_hi_nxt;
    logic                 w_rw_nxt;
    logic                 w_oe_nxt;
    logic [15:0]          w_addr_nxt;
    logic                 w_wr_en_nxt;
    logic [7:0]           w_wr_data_nxt;
    logic                 w_busy_nxt;
    logic [7:0]           w_byte;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_scl_d   <= 1'b1;
            r_sda_d   <= 1'b1;
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_shift   <= '0;
            r_addr_hi <= '0;
            r_rw      <= 1'b0;
            r_sda_oe  <= 1'b0;
            r_addr    <= '0;
            r_wr_en   <= 1'b0;
            r_wr_data <= '0;
            r_busy    <= 1'b0;
        end else begin
            r_scl_d   <= w_scl;
            r_sda_d   <= w_sda;
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_shift   <= w_shift_nxt;
            r_addr_hi <= w_addr_hi_nxt;
            r_rw      <= w_rw_nxt;
            r_sda_oe  <= w_oe_nxt;
            r_addr    <= w_addr_nxt;
            r_wr_en   <= w_wr_en_nxt;
            r_wr_data <= w_wr_data_nxt;
            r_busy    <= w_busy_nxt;
        end
    end

    // Next-state and registered-output logic; START/STOP override every state.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_shift_nxt   = r_shift;
        w_addr_hi_nxt = r_addr_hi;
        w_rw_nxt      = r_rw;
        w_oe_nxt      = r_sda_oe;
        w_addr_nxt    = r_addr;
        w_wr_en_nxt   = 1'b0;
        w_wr_data_nxt = r_wr_data;
        w_busy_nxt    = r_busy;
        w_byte        = {r_shift[6:0], w_sda};

        if (r_wr_en) begin
            w_addr_nxt = r_addr + 16'd1;
        end

        if (w_start) begin
            w_state_nxt = ST_DEV;
            w_cnt_nxt   = '0;
            w_oe_nxt    = 1'b0;
            w_busy_nxt  = 1'b1;
        end else if (w_stop) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
            w_oe_nxt    = 1'b0;
            w_busy_nxt  = 1'b0;
        end else begin
            case (r_state)
                ST_DEV, ST_AHI, ST_ALO, ST_WDATA: begin
                    if (w_scl_rise) begin
                        w_shift_nxt = w_byte;
                        w_cnt_nxt   = r_cnt + BIT_CNT_W'(1);
                        if (r_cnt == BIT_CNT_W'(7)) begin
                            w_cnt_nxt = '0;
                            case (r_state)
                                ST_DEV: begin
                                    if (dev_match(w_byte, DEV_ADDR)) begin
                                        w_state_nxt = ST_ACK_DEV;
                                        w_rw_nxt    = w_byte[0];
                                    end else begin
                                        w_state_nxt = ST_IDLE;
                                        w_busy_nxt  = 1'b0;
                                    end
                                end
                                ST_AHI: begin
                                    w_addr_hi_nxt = w_byte;
                                    w_state_nxt   = ST_ACK_AHI;
                                end
                                ST_ALO: begin
                                    w_addr_nxt  = {r_addr_hi, w_byte};
                                    w_state_nxt = ST_ACK_ALO;
                                end
                                default: begin
                                    w_wr_en_nxt   = 1'b1;
                                    w_wr_data_nxt = w_byte;
                                    w_state_nxt   = ST_ACK_W;
                                end
                            endcase
                        end
                    end
                end

                // r_cnt==0: waiting for the low phase to start driving ACK; 1: ACK held.
                ST_ACK_DEV, ST_ACK_AHI, ST_ACK_ALO, ST_ACK_W: begin
                    if (w_scl_fall) begin
                        if (r_cnt == '0) begin
                            w_oe_nxt  = 1'b1;
                            w_cnt_nxt = BIT_CNT_W'(1);
                            if (r_state == ST_ACK_DEV) begin
                                w_shift_nxt = reg_rd_data;
                            end
                        end else begin
                            w_cnt_nxt = '0;
                            w_oe_nxt  = 1'b0;
                            case (r_state)
                                ST_ACK_DEV: begin
                                    if (r_rw) begin
                                        w_state_nxt = ST_RDATA;
                                        w_oe_nxt    = ~r_shift[7];
                                    end else begin
                                        w_state_nxt = ST_AHI;
                                    end
                                end
                                ST_ACK_AHI: w_state_nxt = ST_ALO;
                                default:    w_state_nxt = ST_WDATA;
                            endcase
                        end
                    end
                end

                ST_RDATA: begin
                    if (w_scl_fall) begin
                        if (r_cnt == BIT_CNT_W'(7)) begin
                            w_oe_nxt    = 1'b0;
                            w_cnt_nxt   = '0;
                            w_state_nxt = ST_MACK;
                        end else begin
                            w_shift_nxt = {r_shift[6:0], 1'b0};
                            w_oe_nxt    = ~r_shift[6];
                            w_cnt_nxt   = r_cnt + BIT_CNT_W'(1);
                        end
                    end
                end

                // The address advances past every byte sent, whether ACKed or NACKed.
                ST_MACK: begin
                    if (w_scl_rise) begin
                        w_addr_nxt = r_addr + 16'd1;
                        if (w_sda) begin
                            w_state_nxt = ST_IDLE;
                        end else begin
                            w_cnt_nxt = BIT_CNT_W'(1);
                        end
                    end else if (w_scl_fall && (r_cnt == BIT_CNT_W'(1))) begin
                        w_shift_nxt = reg_rd_data;
                        w_oe_nxt    = ~reg_rd_data[7];
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_RDATA;
                    end
                end

                ST_IDLE: begin
                    w_oe_nxt = 1'b0;
                end

                default: begin
                    w_state_nxt = ST_IDLE;
                    w_oe_nxt    = 1'b0;
                end
            endcase
        end
    end

    assign sda_oe      = r_sda_oe;
    assign reg_addr    = r_addr;
    assign reg_wr_en   = r_wr_en;
    assign reg_wr_data = r_wr_data;
    assign busy        = r_busy;

endmodule

// File: tb/tb_i2c_reg_responder.sv
// Bench for i2c_reg_responder: bit-level I2C master, emulated register file,
// and a byte-level reference model of the expected register traffic.
module tb_i2c_reg_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        scl_m = 1'b1;
    logic        sda_m = 1'b1;
    logic        sda_bus;
    logic        sda_oe;
    logic [15:0] reg_addr;
    logic        reg_wr_en;
    logic [7:0]  reg_wr_data;
    logic [7:0]  reg_rd_data;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    assign sda_bus = sda_m & ~sda_oe;
    always #5 clk = ~clk;

    i2c_reg_responder #(.DEV_ADDR(7'h3C), .FILT_LEN(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .scl_i       (scl_m),
        .sda_i       (sda_bus),
        .sda_oe      (sda_oe),
        .reg_addr    (reg_addr),
        .reg_wr_en   (reg_wr_en),
        .reg_wr_data (reg_wr_data),
        .reg_rd_data (reg_rd_data),
        .busy        (busy)
    );

    function automatic logic [7:0] init_val(input logic [15:0] a);
        case (a)
            16'h300A: return 8'h56;
            16'h300B: return 8'h40;
            16'h4444: return 8'h00;
            default:  return a[15:8] ^ a[7:0] ^ 8'hA5;
        endcase
    endfunction

    // Emulated register file: written only by DUT strobes, read one clk after address.
    logic [7:0]  mem      [0:65535];
    bit          mem_wr   [0:65535];
    logic [23:0] slog     [0:1023];
    int          strobe_cnt = 0;
    int          oe_cnt = 0;

    always @(posedge clk) begin
        reg_rd_data <= mem_wr[reg_addr] ? mem[reg_addr] : init_val(reg_addr);
        if (sda_oe) oe_cnt <= oe_cnt + 1;
        if (reg_wr_en) begin
            mem[reg_addr]    <= reg_wr_data;
            mem_wr[reg_addr] <= 1'b1;
            slog[strobe_cnt[9:0]] <= {reg_addr, reg_wr_data};
            strobe_cnt <= strobe_cnt + 1;
        end
    end

    // Reference model of register contents, updated from the bytes the master sends.
    logic [7:0] ref_mem   [0:65535];
    bit         ref_wr    [0:65535];
    logic [7:0] tx_q      [$];

    function automatic logic [7:0] ref_rd(input logic [15:0] a);
        return ref_wr[a] ? ref_mem[a] : init_val(a);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One bit: 20-clk low phase (data set mid-low), 20-clk high phase (sampled mid-high).
    task automatic bit_xfer(input logic b, output logic s);
        wait_clks(10); sda_m = b;
        wait_clks(10); scl_m = 1'b1;
        wait_clks(10); s = sda_bus;
        wait_clks(10); scl_m = 1'b0;
    endtask

    task automatic i2c_start;
        wait_clks(10); sda_m = 1'b1;
        wait_clks(10); scl_m = 1'b1;
        wait_clks(20); sda_m = 1'b0;
        wait_clks(20); scl_m = 1'b0;
    endtask

    task automatic i2c_stop;
        wait_clks(10); sda_m = 1'b0;
        wait_clks(10); scl_m = 1'b1;
        wait_clks(20); sda_m = 1'b1;
        wait_clks(20);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_xfer(b[i], s);
        bit_xfer(1'b1, s);
        ack = ~s;
    endtask

    task automatic read_byte(output logic [7:0] b, input logic master_ack);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(1'b1, s);
            b[i] = s;
        end
        bit_xfer(~master_ack, s);
    endtask

    task automatic addr_phase(input logic [15:0] a, input string tag);
        logic ack;
        i2c_start;
        write_byte(8'h78, ack);   check({tag, " ack_dev"}, 32'(ack), 32'd1);
        write_byte(a[15:8], ack); check({tag, " ack_ahi"}, 32'(ack), 32'd1);
        write_byte(a[7:0], ack);  check({tag, " ack_alo"}, 32'(ack), 32'd1);
    endtask

    // Write tx_q starting at a; expect one strobe per byte at consecutive wrapping addresses.
    task automatic do_write(input logic [15:0] a, input string tag);
        logic ack;
        logic [23:0] got;
        int base;
        base = strobe_cnt;
        addr_phase(a, tag);
        for (int i = 0; i < tx_q.size(); i++) begin
            write_byte(tx_q[i], ack);
            check({tag, " ack_data"}, 32'(ack), 32'd1);
        end
        i2c_stop;
        check({tag, " strobe_count"}, 32'(strobe_cnt - base), 32'(tx_q.size()));
        for (int i = 0; i < tx_q.size(); i++) begin
            got = (base + i < strobe_cnt) ? slog[10'(base + i)] : 24'hxxxxxx;
            check({tag, " strobe"}, 32'(got), 32'({16'(a + 16'(i)), tx_q[i]}));
            ref_mem[16'(a + 16'(i))] = tx_q[i];
            ref_wr[16'(a + 16'(i))]  = 1'b1;
        end
        check({tag, " final_addr"}, 32'(reg_addr), 32'(16'(a + 16'(tx_q.size()))));
        check({tag, " busy_after_stop"}, 32'(busy), 32'd0);
    endtask

    // Set address, repeated START, read n bytes (ACK all but the last), STOP.
    task automatic do_read(input logic [15:0] a, input int n, input string tag);
        logic ack;
        logic [7:0] b;
        int base;
        base = strobe_cnt;
        addr_phase(a, tag);
        i2c_start;
        write_byte(8'h79, ack);
        check({tag, " ack_rd_dev"}, 32'(ack), 32'd1);
        for (int i = 0; i < n; i++) begin
            read_byte(b, i != n - 1);
            check({tag, " rd_byte"}, 32'(b), 32'(ref_rd(16'(a + 16'(i)))));
        end
        i2c_stop;
        check({tag, " rd_final_addr"}, 32'(reg_addr), 32'(16'(a + 16'(n))));
        check({tag, " rd_no_strobe"}, 32'(strobe_cnt - base), 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic ack;
        logic s;
        int base;
        int oe_base;
        logic [15:0] ra;
        int rn;

        wait_clks(5);
        check("rst sda_oe", 32'(sda_oe), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst reg_addr", 32'(reg_addr), 32'd0);
        check("rst reg_wr_en", 32'(reg_wr_en), 32'd0);
        check("rst reg_wr_data", 32'(reg_wr_data), 32'd0);
        rst = 1'b0;
        wait_clks(10);

        tx_q = '{8'h82};
        do_write(16'h3008, "single_write");

        tx_q = '{8'h11, 8'h22, 8'h33};
        do_write(16'h5000, "burst_write");

        do_read(16'h300A, 2, "read_2");

        // Foreign address: never ACKed and busy drops after the address byte.
        base = strobe_cnt;
        oe_base = oe_cnt;
        i2c_start;
        write_byte(8'h42, ack);
        check("nomatch ack", 32'(ack), 32'd0);
        check("nomatch busy", 32'(busy), 32'd0);
        i2c_stop;
        check("nomatch oe_cycles", 32'(oe_cnt - oe_base), 32'd0);
        check("nomatch strobes", 32'(strobe_cnt - base), 32'd0);

        // STOP after a partial data byte.
        base = strobe_cnt;
        addr_phase(16'h1234, "partial");
        for (int i = 0; i < 4; i++) bit_xfer(1'b0, s);
        i2c_stop;
        check("partial strobes", 32'(strobe_cnt - base), 32'd0);
        check("partial busy", 32'(busy), 32'd0);
        check("partial sda_oe", 32'(sda_oe), 32'd0);
        check("partial reg_addr", 32'(reg_addr), 32'h1234);

        // Short SDA glitches while SCL is high must not look like START.
        sda_m = 1'b0; wait_clks(1); sda_m = 1'b1; wait_clks(20);
        check("glitch1 busy", 32'(busy), 32'd0);
        sda_m = 1'b0; wait_clks(2); sda_m = 1'b1; wait_clks(20);
        check("glitch2 busy", 32'(busy), 32'd0);

        tx_q = '{8'hA1, 8'hB2};
        do_write(16'hFFFF, "wrap_write");

        // Reset while the DUT is driving a 0 data bit.
        addr_phase(16'h4444, "rst_read");
        i2c_start;
        write_byte(8'h79, ack);
        check("rst_read ack_rd_dev", 32'(ack), 32'd1);
        wait_clks(10);
        check("rst_read oe_before", 32'(sda_oe), 32'd1);
        rst = 1'b1;
        wait_clks(1);
        check("rst_read oe_after", 32'(sda_oe), 32'd0);
        check("rst_read busy", 32'(busy), 32'd0);
        check("rst_read reg_addr", 32'(reg_addr), 32'd0);
        wait_clks(3);
        rst = 1'b0;
        oe_base = oe_cnt;
        base = strobe_cnt;
        for (int i = 0; i < 9; i++) bit_xfer(1'b1, s);
        i2c_stop;
        check("post_rst oe_cycles", 32'(oe_cnt - oe_base), 32'd0);
        check("post_rst strobes", 32'(strobe_cnt - base), 32'd0);
        check("post_rst busy", 32'(busy), 32'd0);

        // Randomized write-then-readback transactions.
        for (int t = 0; t < 5; t++) begin
            ra = (t == 0) ? 16'hFFFE : 16'($urandom);
            rn = int'($urandom_range(1, 3));
            tx_q.delete();
            for (int i = 0; i < rn; i++) tx_q.push_back(8'($urandom));
            do_write(ra, "rand_write");
            do_read(ra, rn + 1, "rand_read");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
